// File: rtl/rgb2yuv_stripe_scheduler.sv
// Frame-job sequencer for ff_rgb24toyv12_c: one component call per STRIPE_ROWS-row stripe, >=3 cycles/stripe
// plus component latency; a call is held stable while cmp_busy. Optional perf counters: RGB2YUV_SCHED_PERF_EN.
module rgb2yuv_stripe_scheduler #(
  parameter int STRIPE_ROWS = 16,
  parameter int ROWS_W      = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [63:0] job_src,
  input  logic [63:0] job_ydst,
  input  logic [63:0] job_udst,
  input  logic [63:0] job_vdst,
  input  logic [31:0] job_width,
  input  logic [31:0] job_height,
  input  logic [31:0] job_src_stride,
  input  logic [31:0] job_lum_stride,
  input  logic [31:0] job_chrom_stride,
  output logic        job_done,
  output logic [15:0] stripe_idx,
  output logic        cmp_start,
  input  logic        cmp_busy,
  input  logic        cmp_done,
  output logic        cmp_stall,
  output logic [63:0] cmp_src,
  output logic [63:0] cmp_ydst,
  output logic [63:0] cmp_udst,
  output logic [63:0] cmp_vdst,
  output logic [31:0] cmp_width,
  output logic [31:0] cmp_height,
  output logic [31:0] cmp_src_stride,
  output logic [31:0] cmp_lum_stride,
  output logic [31:0] cmp_chrom_stride
`ifdef RGB2YUV_SCHED_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stall_cycles
`endif
);

  if (STRIPE_ROWS < 2 || (STRIPE_ROWS % 2) != 0 || ROWS_W < 1 || ROWS_W > 64) begin : g_bad_param
    $error("rgb2yuv_stripe_scheduler: STRIPE_ROWS must be even and >= 2, ROWS_W in 1..64");
  end

  localparam logic [ROWS_W-1:0] STRIPE = ROWS_W'(STRIPE_ROWS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALL = 3'd1,
    WAIT = 3'd2,
    ADV  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [ROWS_W-1:0] rows_left;
  logic [ROWS_W-1:0] cur_rows;
  logic [ROWS_W-1:0] rows_rem;
  logic [ROWS_W-1:0] job_rows;
  logic              accept;
  logic              job_empty;

  function automatic logic [ROWS_W-1:0] clip(input logic [ROWS_W-1:0] r);
    return (r < STRIPE) ? r : STRIPE;
  endfunction

  // Stride is sign-extended so the modulo-2^64 product walks bottom-up frames correctly.
  function automatic logic [63:0] step(input logic [31:0] stride, input logic [ROWS_W-1:0] rows);
    return {{32{stride[31]}}, stride} * 64'(rows);
  endfunction

  assign job_rows   = ROWS_W'(job_height);
  assign job_empty  = (job_width == 32'd0) || (job_rows == '0);
  assign accept     = job_valid && job_ready;
  assign rows_rem   = rows_left - cur_rows;
  assign cmp_height = 32'(cur_rows);

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Handshake outputs are masked while resetn is low so an abandoned call is never re-presented.
  always_comb begin
    state_d   = state_q;
    job_ready = 1'b0;
    job_done  = 1'b0;
    cmp_start = 1'b0;
    cmp_stall = 1'b1;
    case (state_q)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) state_d = job_empty ? DONE : CALL;
      end
      CALL: begin
        cmp_start = resetn;
        if (!cmp_busy) state_d = WAIT;
      end
      WAIT: begin
        cmp_stall = !resetn;
        if (cmp_done) state_d = ADV;
      end
      ADV: begin
        state_d = (rows_rem == '0) ? DONE : CALL;
      end
      DONE: begin
        job_done = resetn;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rows_left        <= '0;
      cur_rows         <= '0;
      stripe_idx       <= '0;
      cmp_src          <= '0;
      cmp_ydst         <= '0;
      cmp_udst         <= '0;
      cmp_vdst         <= '0;
      cmp_width        <= '0;
      cmp_src_stride   <= '0;
      cmp_lum_stride   <= '0;
      cmp_chrom_stride <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (job_valid) begin
            rows_left        <= job_rows;
            cur_rows         <= clip(job_rows);
            stripe_idx       <= '0;
            cmp_src          <= job_src;
            cmp_ydst         <= job_ydst;
            cmp_udst         <= job_udst;
            cmp_vdst         <= job_vdst;
            cmp_width        <= job_width;
            cmp_src_stride   <= job_src_stride;
            cmp_lum_stride   <= job_lum_stride;
            cmp_chrom_stride <= job_chrom_stride;
          end
        end
        ADV: begin
          rows_left <= rows_rem;
          cmp_src   <= cmp_src  + step(cmp_src_stride, cur_rows);
          cmp_ydst  <= cmp_ydst + step(cmp_lum_stride, cur_rows);
          cmp_udst  <= cmp_udst + step(cmp_chrom_stride, cur_rows >> 1);
          cmp_vdst  <= cmp_vdst + step(cmp_chrom_stride, cur_rows >> 1);
          if (rows_rem != '0) begin
            stripe_idx <= stripe_idx + 16'd1;
            cur_rows   <= clip(rows_rem);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RGB2YUV_SCHED_PERF_EN
  // The accept cycle itself counts, hence the load of 1.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      perf_cycles       <= '0;
      perf_stall_cycles <= '0;
    end else if (accept) begin
      perf_cycles       <= 32'd1;
      perf_stall_cycles <= '0;
    end else if (state_q != IDLE) begin
      if (perf_cycles != 32'hFFFF_FFFF) perf_cycles <= perf_cycles + 32'd1;
      if (state_q == CALL && cmp_busy && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rgb2yuv_stripe_scheduler.sv
// Bench for rgb2yuv_stripe_scheduler: job table plus reset/back-pressure sequences, per-call scoreboard.
module tb_rgb2yuv_stripe_scheduler;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [63:0] job_src = '0, job_ydst = '0, job_udst = '0, job_vdst = '0;
  logic [31:0] job_width = '0, job_height = '0;
  logic [31:0] job_src_stride = '0, job_lum_stride = '0, job_chrom_stride = '0;
  logic        job_done;
  logic [15:0] stripe_idx;
  logic        cmp_start;
  logic        cmp_busy = 1'b0;
  logic        cmp_done = 1'b0;
  logic        cmp_stall;
  logic [63:0] cmp_src, cmp_ydst, cmp_udst, cmp_vdst;
  logic [31:0] cmp_width, cmp_height, cmp_src_stride, cmp_lum_stride, cmp_chrom_stride;
`ifdef RGB2YUV_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stall_cycles;
`endif

  rgb2yuv_stripe_scheduler dut (
    .clock(clock), .resetn(resetn),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_src(job_src), .job_ydst(job_ydst), .job_udst(job_udst), .job_vdst(job_vdst),
    .job_width(job_width), .job_height(job_height),
    .job_src_stride(job_src_stride), .job_lum_stride(job_lum_stride), .job_chrom_stride(job_chrom_stride),
    .job_done(job_done), .stripe_idx(stripe_idx),
    .cmp_start(cmp_start), .cmp_busy(cmp_busy), .cmp_done(cmp_done), .cmp_stall(cmp_stall),
    .cmp_src(cmp_src), .cmp_ydst(cmp_ydst), .cmp_udst(cmp_udst), .cmp_vdst(cmp_vdst),
    .cmp_width(cmp_width), .cmp_height(cmp_height),
    .cmp_src_stride(cmp_src_stride), .cmp_lum_stride(cmp_lum_stride), .cmp_chrom_stride(cmp_chrom_stride)
`ifdef RGB2YUV_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] src, ydst, udst, vdst;
    logic [31:0] width, height, ss, ls, cs;
    int          calls;
    logic [63:0] l_src, l_ydst, l_udst, l_vdst;
    logic [31:0] l_h;
  } vec_t;

  typedef struct {
    logic [63:0] src, ydst, udst, vdst;
    logic [31:0] h, w;
    logic [15:0] idx;
  } call_t;

  call_t       exp_q[$];
  int          vecs = 0, errs = 0;
  int          cyc = 0, acc_cyc = 0, done_cyc = 0;
  int          xfers = 0, starts = 0, dones = 0;
  int          busy_left = 0;
  logic [63:0] last_src, last_ydst, last_udst, last_vdst;
  logic [31:0] last_h;
  logic        hold = 1'b0;
  logic [63:0] snap_src;
  logic [31:0] snap_h;
  logic [15:0] snap_idx;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference stripe walk, written with signed 64-bit products.
  task automatic push_expected(input vec_t v);
    logic signed [63:0] ss, ls, cs;
    logic [63:0] s, y, u, w;
    int left, rows;
    call_t c;
    ss = $signed(v.ss); ls = $signed(v.ls); cs = $signed(v.cs);
    s = v.src; y = v.ydst; u = v.udst; w = v.vdst;
    left = (v.width == 0) ? 0 : int'(v.height);
    for (int i = 0; left > 0; i++) begin
      rows = (left < 16) ? left : 16;
      c.src = s; c.ydst = y; c.udst = u; c.vdst = w;
      c.h = rows; c.w = v.width; c.idx = 16'(i);
      exp_q.push_back(c);
      s = s + ss * rows;
      y = y + ls * rows;
      u = u + cs * (rows / 2);
      w = w + cs * (rows / 2);
      left -= rows;
    end
  endtask

  // Component model and call monitor; drives busy/done at the falling edge.
  initial begin : mon
    int    done_timer;
    bit    consume;
    call_t e;
    done_timer = -1;
    consume = 0;
    forever begin
      @(negedge clock);
      if (consume) begin cmp_done = 1'b0; consume = 0; end
      if (!resetn) begin
        cmp_busy = 1'b0; cmp_done = 1'b0; done_timer = -1; hold = 1'b0;
      end else begin
        if (done_timer > 0) done_timer--;
        if (done_timer == 0) begin cmp_done = 1'b1; done_timer = -1; end
        if (job_done) begin dones++; done_cyc = cyc; end
        if (cmp_start) starts++;
        if (cmp_start && busy_left > 0) begin
          cmp_busy = 1'b1;
          busy_left--;
          if (!hold) begin
            hold = 1'b1; snap_src = cmp_src; snap_h = cmp_height; snap_idx = stripe_idx;
          end else begin
            chk("busy_hold_src", cmp_src, snap_src);
            chk("busy_hold_height", cmp_height, snap_h);
          end
        end else begin
          cmp_busy = 1'b0;
        end
        if (cmp_start && !cmp_busy) begin
          xfers++;
          done_timer = 5;
          if (hold) begin
            chk("busy_hold_idx", stripe_idx, snap_idx);
            hold = 1'b0;
          end
          if (exp_q.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected_call: got call at cycle %0d, expected none", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("call_src", cmp_src, e.src);
            chk("call_ydst", cmp_ydst, e.ydst);
            chk("call_udst", cmp_udst, e.udst);
            chk("call_vdst", cmp_vdst, e.vdst);
            chk("call_height", cmp_height, e.h);
            chk("call_width", cmp_width, e.w);
            chk("call_idx", stripe_idx, e.idx);
          end
          last_src = cmp_src; last_ydst = cmp_ydst; last_udst = cmp_udst; last_vdst = cmp_vdst;
          last_h = cmp_height;
        end
        if (cmp_done && !cmp_stall) consume = 1;
      end
    end
  end

  task automatic drive_job(input vec_t v);
    @(posedge clock); #1;
    job_src = v.src; job_ydst = v.ydst; job_udst = v.udst; job_vdst = v.vdst;
    job_width = v.width; job_height = v.height;
    job_src_stride = v.ss; job_lum_stride = v.ls; job_chrom_stride = v.cs;
    job_valid = 1'b1;
    chk("job_ready_idle", job_ready, 1);
    @(posedge clock); #1;
    acc_cyc = cyc;
    job_valid = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input int busy);
    int bx, bd, bs, t;
    push_expected(v);
    bx = xfers; bd = dones; bs = starts;
    busy_left = busy;
    drive_job(v);
    t = 0;
    while (dones == bd && t < 3000) begin @(negedge clock); t++; end
    chk("done_within_budget", t < 3000, 1);
    repeat (4) @(negedge clock);
    chk("calls", xfers - bx, v.calls);
    chk("start_cycles", starts - bs, v.calls + busy);
    chk("done_pulses", dones - bd, 1);
    chk("final_stripe_idx", stripe_idx, (v.calls == 0) ? 0 : v.calls - 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    if (v.calls == 0) chk("empty_done_latency", done_cyc - acc_cyc, 0);
    if (v.calls > 0) begin
      chk("last_src", last_src, v.l_src);
      chk("last_ydst", last_ydst, v.l_ydst);
      chk("last_udst", last_udst, v.l_udst);
      chk("last_vdst", last_vdst, v.l_vdst);
      chk("last_height", last_h, v.l_h);
    end
  endtask

  initial begin : main
    vec_t tbl[7];
    vec_t basic;
    int   bx, bd, t;
    tbl[0] = '{64'h1000, 64'h8000, 64'hA000, 64'hB000, 32'd64, 32'd32, 32'd192, 32'd64, 32'd32,
               2, 64'h1C00, 64'h8400, 64'hA100, 64'hB100, 32'd16};
    tbl[1] = '{64'h1000, 64'h8000, 64'hA000, 64'hB000, 32'd64, 32'd35, 32'd192, 32'd64, 32'd32,
               3, 64'h2800, 64'h8800, 64'hA200, 64'hB200, 32'd3};
    tbl[2] = '{64'h10000, 64'h8000, 64'hA000, 64'hB000, 32'd64, 32'd20, 32'hFFFF_FF40, 32'd64, 32'd32,
               2, 64'hF400, 64'h8400, 64'hA100, 64'hB100, 32'd4};
    tbl[3] = '{64'h1000, 64'h8000, 64'hA000, 64'hB000, 32'd64, 32'd0, 32'd192, 32'd64, 32'd32,
               0, 64'h0, 64'h0, 64'h0, 64'h0, 32'd0};
    tbl[4] = '{64'h1000, 64'h8000, 64'hA000, 64'hB000, 32'd0, 32'd16, 32'd192, 32'd64, 32'd32,
               0, 64'h0, 64'h0, 64'h0, 64'h0, 32'd0};
    tbl[5] = '{64'h1000, 64'h8000, 64'hA000, 64'hB000, 32'd64, 32'd1, 32'd192, 32'd64, 32'd32,
               1, 64'h1000, 64'h8000, 64'hA000, 64'hB000, 32'd1};
    tbl[6] = '{64'h1000, 64'h8000, 64'hA000, 64'hB000, 32'd64, 32'd17, 32'd192, 32'hFFFF_FFC0, 32'd32,
               2, 64'h1C00, 64'h7C00, 64'hA100, 64'hB100, 32'd1};
    basic = tbl[0];

    // Reset: handshake outputs are inactive even while reset is held.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("in_reset_start", cmp_start, 0);
    chk("in_reset_stall", cmp_stall, 1);
    @(posedge clock); #1 resetn = 1'b1;
    @(negedge clock);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_job_done", job_done, 0);
    chk("rst_cmp_start", cmp_start, 0);
    chk("rst_cmp_stall", cmp_stall, 1);
    chk("rst_stripe_idx", stripe_idx, 0);
    chk("rst_cmp_src", cmp_src, 0);
    chk("rst_cmp_height", cmp_height, 0);

    for (int i = 0; i < 7; i++) begin
      run_job(tbl[i], 0);
`ifdef RGB2YUV_SCHED_PERF_EN
      if (i == 3) chk("perf_cycles_empty", perf_cycles, 2);
`endif
    end

    // Back-pressure: busy for 7 CALL cycles on a single-stripe job.
    basic.height = 32'd16; basic.calls = 1;
    basic.l_src = 64'h1000; basic.l_ydst = 64'h8000; basic.l_udst = 64'hA000; basic.l_vdst = 64'hB000;
    run_job(basic, 7);
`ifdef RGB2YUV_SCHED_PERF_EN
    chk("perf_stall_cycles", perf_stall_cycles, 7);
`endif

    // Reset while waiting on the second stripe's return.
    basic = tbl[0];
    push_expected(basic);
    bx = xfers; bd = dones;
    drive_job(basic);
    t = 0;
    while (xfers < bx + 2 && t < 500) begin @(negedge clock); t++; end
    chk("second_call_seen", xfers - bx, 2);
    @(posedge clock); #1;
    chk("in_wait_stall", cmp_stall, 0);
    resetn = 1'b0;
    @(negedge clock);
    chk("reset_wait_stall", cmp_stall, 1);
    chk("reset_wait_start", cmp_start, 0);
    @(posedge clock); #1 resetn = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", job_ready, 1);
    chk("post_rst_start", cmp_start, 0);
    chk("post_rst_stall", cmp_stall, 1);
    chk("post_rst_idx", stripe_idx, 0);
    repeat (12) @(negedge clock);
    chk("no_done_after_abort", dones - bd, 0);
    chk("no_call_after_abort", xfers - bx, 2);
    exp_q.delete();
    run_job(tbl[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vecs, errs);
    $fatal(1, "timeout");
  end

endmodule
